// File: rtl/program_sequencer_stack_pkg.sv
// Shared constants and types for the program sequencer and its return-address stack.
package program_sequencer_stack_pkg;

   localparam int unsigned ADDR_W_DEF      = 8;
   localparam int unsigned STACK_DEPTH_DEF = 4;
   localparam int unsigned SP_W_DEF        = 3;

   localparam logic [7:0] RESET_ADDR = 8'h00;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Bounded LIFO of return addresses. The caller must check full/empty before pushing or popping;
// this block does not detect misuse.
module return_addr_stack #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SP_W   = 3
) (
   input  logic              i_clk,
   input  logic              i_sync_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_top,
   output logic [SP_W-1:0]   o_sp,
   output logic              o_full,
   output logic              o_empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic [DATA_W-1:0] w_top;

   always_ff @(posedge i_clk) begin
      if (i_sync_reset) begin
         r_sp <= '0;
      end else if (i_push) begin
         r_sp <= r_sp + SP_W'(1);
      end else if (i_pop) begin
         r_sp <= r_sp - SP_W'(1);
      end
   end

   // Entry storage is left unreset; only occupancy matters after reset.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (i_push && (r_sp == SP_W'(i))) begin
            r_mem[i] <= i_data;
         end
      end
   end

   always_comb begin
      w_top = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (r_sp == SP_W'(i + 1)) begin
            w_top = r_mem[i];
         end
      end
   end

   assign o_top   = w_top;
   assign o_sp    = r_sp;
   assign o_full  = (r_sp == SP_W'(DEPTH));
   assign o_empty = (r_sp == '0);

endmodule

// File: rtl/program_sequencer_stack.sv
// Program-counter sequencer: selects the next program-memory address from the decoder's
// flow-control strobes, with a bounded return-address stack and a sticky fault on stack misuse.
module program_sequencer_stack
   import program_sequencer_stack_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int unsigned SP_W        = SP_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_sync_reset,
   input  logic              i_jmp,
   input  logic              i_jmp_nz,
   input  logic              i_dont_jmp,
   input  logic              i_call,
   input  logic              i_ret,
   input  logic [3:0]        i_ir_nibble,
   input  logic              i_hold,
   output logic [ADDR_W-1:0] o_pm_addr,
   output logic [ADDR_W-1:0] o_pc,
   output logic [SP_W-1:0]   o_sp,
   output logic              o_stack_empty,
   output logic              o_stack_full,
   output logic              o_fault
);

   state_e            r_state;
   state_e            w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pm_addr;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_top;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;

   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_target = ADDR_W'({i_ir_nibble, 4'h0});

   return_addr_stack #(
      .DATA_W (ADDR_W),
      .DEPTH  (STACK_DEPTH),
      .SP_W   (SP_W)
   ) u_stack (
      .i_clk        (i_clk),
      .i_sync_reset (i_sync_reset),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_data       (w_pc_inc),
      .o_top        (w_top),
      .o_sp         (o_sp),
      .o_full       (w_full),
      .o_empty      (w_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_sync_reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Misuse is judged only for a strobe that would actually win arbitration.
   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_RUN && !i_hold) begin
         if (i_ret) begin
            if (w_empty) w_state_next = ST_FAULT;
         end else if (i_call && w_full) begin
            w_state_next = ST_FAULT;
         end
      end
   end

   always_comb begin
      w_pm_addr = w_pc_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      if (i_sync_reset) begin
         w_pm_addr = ADDR_W'(RESET_ADDR);
      end else if (r_state == ST_FAULT || i_hold) begin
         w_pm_addr = r_pc;
      end else if (i_ret) begin
         if (w_empty) begin
            w_pm_addr = r_pc;
         end else begin
            w_pm_addr = w_top;
            w_pop     = 1'b1;
         end
      end else if (i_call) begin
         if (w_full) begin
            w_pm_addr = r_pc;
         end else begin
            w_pm_addr = w_target;
            w_push    = 1'b1;
         end
      end else if (i_jmp || (i_jmp_nz && !i_dont_jmp)) begin
         w_pm_addr = w_target;
      end
   end

   always_ff @(posedge i_clk) begin
      r_pc <= w_pm_addr;
   end

   assign o_pm_addr     = w_pm_addr;
   assign o_pc          = r_pc;
   assign o_stack_empty = w_empty;
   assign o_stack_full  = w_full;
   assign o_fault       = (r_state == ST_FAULT);

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Scoreboard bench for program_sequencer_stack: directed plan then randomized strobes,
// checked against a queue-based model of the sequencing rules.
module tb_program_sequencer_stack;

   logic       clk;
   logic       sync_reset;
   logic       jmp, jmp_nz, dont_jmp, call, ret, hold;
   logic [3:0] ir_nibble;
   logic [7:0] pm_addr, pc;
   logic [2:0] sp;
   logic       stack_empty, stack_full, fault;

   program_sequencer_stack dut (
      .i_clk         (clk),
      .i_sync_reset  (sync_reset),
      .i_jmp         (jmp),
      .i_jmp_nz      (jmp_nz),
      .i_dont_jmp    (dont_jmp),
      .i_call        (call),
      .i_ret         (ret),
      .i_ir_nibble   (ir_nibble),
      .i_hold        (hold),
      .o_pm_addr     (pm_addr),
      .o_pc          (pc),
      .o_sp          (sp),
      .o_stack_empty (stack_empty),
      .o_stack_full  (stack_full),
      .o_fault       (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      tag;
      logic [7:0] pm;
      logic [7:0] pc;
      int         sp;
      bit         empty;
      bit         full;
      bit         fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model state
   logic [7:0] m_pc = 8'h00;
   logic [7:0] m_stk[$];
   bit         m_fault = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input string tag, input bit r, input bit h, input bit j, input bit jn,
                       input bit dz, input bit c, input bit rt, input logic [3:0] nib);
      exp_t       e;
      logic [7:0] tgt;
      logic [7:0] nxt;
      @(negedge clk);
      sync_reset = r; hold = h; jmp = j; jmp_nz = jn; dont_jmp = dz;
      call = c; ret = rt; ir_nibble = nib;
      tgt = {nib, 4'h0};
      if (r) begin
         nxt = 8'h00;
         m_stk.delete();
         m_fault = 1'b0;
      end else if (m_fault || h) begin
         nxt = m_pc;
      end else if (rt) begin
         if (m_stk.size() == 0) begin
            nxt = m_pc;
            m_fault = 1'b1;
         end else begin
            nxt = m_stk.pop_back();
         end
      end else if (c) begin
         if (m_stk.size() == 4) begin
            nxt = m_pc;
            m_fault = 1'b1;
         end else begin
            m_stk.push_back(8'((int'(m_pc) + 1) % 256));
            nxt = tgt;
         end
      end else if (j || (jn && !dz)) begin
         nxt = tgt;
      end else begin
         nxt = 8'((int'(m_pc) + 1) % 256);
      end
      m_pc    = nxt;
      e.tag   = tag;
      e.pm    = nxt;
      e.pc    = nxt;
      e.sp    = m_stk.size();
      e.empty = (m_stk.size() == 0);
      e.full  = (m_stk.size() == 4);
      e.fault = m_fault;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 4'h0);
   endtask

   // Monitor: pm_addr is checked mid-low-phase, registered state just after the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".pm_addr"}, 32'(pm_addr), 32'(e.pm));
            @(posedge clk);
            #1;
            chk({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
            chk({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
            chk({e.tag, ".empty"}, 32'(stack_empty), 32'(e.empty));
            chk({e.tag, ".full"}, 32'(stack_full), 32'(e.full));
            chk({e.tag, ".fault"}, 32'(fault), 32'(e.fault));
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      sync_reset = 1'b1; hold = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
      call = 1'b0; ret = 1'b0; ir_nibble = 4'h0;

      step("reset", 1, 0, 0, 0, 0, 0, 0, 4'h0);
      idle("idle", 5);                                   // pc 1..5
      step("jmp_a0", 0, 0, 1, 0, 0, 0, 0, 4'hA);
      step("jmp_10", 0, 0, 1, 0, 0, 0, 0, 4'h1);
      step("jnz_not_taken", 0, 0, 0, 1, 1, 0, 0, 4'h7);
      step("jnz_taken", 0, 0, 0, 1, 0, 0, 0, 4'h3);
      step("jmp_10b", 0, 0, 1, 0, 0, 0, 0, 4'h1);
      idle("idle12", 2);
      step("call_40", 0, 0, 0, 0, 0, 1, 0, 4'h4);
      idle("idle41", 1);
      step("call_60", 0, 0, 0, 0, 0, 1, 0, 4'h6);
      step("ret_42", 0, 0, 0, 0, 0, 0, 1, 4'h0);
      step("ret_13", 0, 0, 0, 0, 0, 0, 1, 4'h0);
      for (int i = 0; i < 5; i++) step("call_over", 0, 0, 0, 0, 0, 1, 0, 4'(i + 2));
      step("fault_jmp", 0, 0, 1, 0, 0, 0, 0, 4'h9);
      step("fault_ret", 0, 0, 0, 0, 0, 0, 1, 4'h0);
      step("fault_reset", 1, 0, 0, 0, 0, 0, 0, 4'h0);
      step("underflow", 0, 0, 0, 0, 0, 0, 1, 4'h0);
      step("uf_idle", 0, 0, 0, 0, 0, 0, 0, 4'h0);
      step("reset2", 1, 0, 0, 0, 0, 0, 0, 4'h0);
      step("hold_call", 0, 1, 0, 0, 0, 1, 0, 4'h5);
      step("call_50", 0, 0, 0, 0, 0, 1, 0, 4'h5);
      step("jmp_ret", 0, 0, 1, 0, 0, 0, 1, 4'hC);
      step("jmp_f0", 0, 0, 1, 0, 0, 0, 0, 4'hF);
      idle("to_ff", 15);
      step("call_at_ff", 0, 0, 0, 0, 0, 1, 0, 4'h2);
      step("ret_wrap", 0, 0, 0, 0, 0, 0, 1, 4'h0);
      step("jmp_f0b", 0, 0, 1, 0, 0, 0, 0, 4'hF);
      idle("wrap", 16);

      for (int i = 0; i < 2000; i++) begin
         step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
